// File: rtl/ol_pkg.sv
// Shared types and constants for the borrow-save online adder.
// A digit {p,n} has value p - n; {1,1} is a legal alias for zero on inputs.
package ol_pkg;

  typedef logic [1:0] digit_t;

  localparam digit_t DIG_ZERO = 2'b00;
  localparam digit_t DIG_POS  = 2'b10;
  localparam digit_t DIG_NEG  = 2'b01;

  // Online delay of ol_add_digit in enabled cycles.
  localparam int DELTA = 2;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  // Signed value of one borrow-save digit.
  function automatic logic signed [2:0] dig_val(input digit_t d);
    logic signed [2:0] v;
    v = $signed({2'b00, d[1]}) - $signed({2'b00, d[0]});
    return v;
  endfunction

  // Canonical encoding of a value in {-1,0,1}; never produces {1,1}.
  function automatic digit_t dig_enc(input logic signed [1:0] v);
    digit_t d;
    case (v)
      2'sb01:  d = DIG_POS;
      2'sb11:  d = DIG_NEG;
      default: d = DIG_ZERO;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/ol_add_seq_ctrl_if.sv
// Operand/result handshake bundle for ol_add_seq_ctrl.
// With OL_ADD_STREAM_EN defined the bundle also carries the per-digit stream zd/zd_valid.
interface ol_add_seq_ctrl_if #(
  parameter int NDIG = 6
);
  logic                in_valid;
  logic                in_ready;
  logic [2*NDIG-1:0]   x;
  logic [2*NDIG-1:0]   y;
  logic                out_valid;
  logic                out_ready;
  logic [2*NDIG+1:0]   z;
  logic                busy;
`ifdef OL_ADD_STREAM_EN
  logic [1:0]          zd;
  logic                zd_valid;

  modport master (
    output in_valid, x, y, out_ready,
    input  in_ready, out_valid, z, busy, zd, zd_valid
  );

  modport slave (
    input  in_valid, x, y, out_ready,
    output in_ready, out_valid, z, busy, zd, zd_valid
  );
`else
  modport master (
    output in_valid, x, y, out_ready,
    input  in_ready, out_valid, z, busy
  );

  modport slave (
    input  in_valid, x, y, out_ready,
    output in_ready, out_valid, z, busy
  );
`endif
endinterface

// File: rtl/ol_add_digit.sv
// Registered single-digit radix-2 online adder slice, MSD first, online delay 2.
// The digit sum a_i = x_i + y_i is split as a_i = 2*t_(i+1) + w_i, choosing the split of
// +-1 from the sign of the next lower a so that w_i + t_i always stays in {-1,0,1}.
// Output digit z_i = w_i + t_i therefore needs a_(i-2), which sets the delay of two.
module ol_add_digit
  import ol_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   en,
  input  logic   first,
  input  digit_t xd,
  input  digit_t yd,
  output digit_t zd,
  output logic   zd_valid
);

  logic signed [2:0] a_cur;
  logic signed [2:0] a_p;
  logic signed [2:0] a_prev_reg;
  logic signed [1:0] w_reg;
  logic signed [1:0] w_p;
  logic signed [1:0] w_next;
  logic signed [1:0] t_next;
  logic signed [1:0] z_sum;
  logic              a_neg;
  digit_t            zd_reg;
  logic              zd_valid_reg;

  // Split the previous digit sum into transfer/interim parts and form the output digit.
  always_comb begin
    a_cur  = dig_val(xd) + dig_val(yd);
    a_p    = first ? 3'sd0 : a_prev_reg;
    w_p    = first ? 2'sd0 : w_reg;
    a_neg  = a_cur[2];
    t_next = 2'sd0;
    w_next = 2'sd0;
    case (a_p)
      3'sb010: t_next = 2'sb01;
      3'sb110: t_next = 2'sb11;
      3'sb001: begin
        if (a_neg) begin
          t_next = 2'sb00;
          w_next = 2'sb01;
        end else begin
          t_next = 2'sb01;
          w_next = 2'sb11;
        end
      end
      3'sb111: begin
        if (a_neg) begin
          t_next = 2'sb11;
          w_next = 2'sb01;
        end else begin
          t_next = 2'sb00;
          w_next = 2'sb11;
        end
      end
      default: begin
        t_next = 2'sb00;
        w_next = 2'sb00;
      end
    endcase
    z_sum = w_p + t_next;
  end

  // Pipeline state; the first enabled cycle only primes the pipe and yields no digit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_prev_reg   <= 3'sd0;
      w_reg        <= 2'sd0;
      zd_reg       <= DIG_ZERO;
      zd_valid_reg <= 1'b0;
    end else begin
      zd_valid_reg <= en & ~first;
      if (en) begin
        a_prev_reg <= a_cur;
        w_reg      <= w_next;
        zd_reg     <= dig_enc(z_sum);
      end
    end
  end

  assign zd       = zd_reg;
  assign zd_valid = zd_valid_reg;

endmodule

// File: rtl/ol_add_seq_ctrl.sv
// Sequencer for a digit-serial MSD-first borrow-save online adder built on one ol_add_digit.
// Streams NDIG operand digit pairs, flushes the online delay with zero digits, collects
// NDIG+1 sum digits into z and offers z over a valid/ready handshake.
// OL_ADD_STREAM_EN exposes each sum digit on zd/zd_valid as it is produced.
module ol_add_seq_ctrl
  import ol_pkg::*;
#(
  parameter int NDIG = 6
) (
  input logic              clk,
  input logic              rst_n,
  ol_add_seq_ctrl_if.slave bus
);

  localparam int W     = 2 * NDIG;
  localparam int ZW    = 2 * NDIG + 2;
  localparam int CNT_W = $clog2(NDIG + 1);

  // FLUSH spends DELTA enabled cycles plus one drain cycle in which the last
  // registered slice digit is shifted into z, so z is complete on entry to DONE.
  localparam logic [CNT_W-1:0] RUN_LAST   = CNT_W'(NDIG - 1);
  localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(DELTA);

  state_t           state_reg;
  state_t           state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic [W-1:0]     xs_reg;
  logic [W-1:0]     ys_reg;
  logic [ZW-1:0]    z_reg;
  logic             accept;
  logic             slice_en;
  logic             slice_first;
  digit_t           slice_xd;
  digit_t           slice_yd;
  digit_t           slice_zd;
  logic             slice_zd_valid;

  // State and digit counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Next-state logic and slice drive.
  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    accept      = 1'b0;
    slice_en    = 1'b0;
    slice_first = 1'b0;
    slice_xd    = DIG_ZERO;
    slice_yd    = DIG_ZERO;
    case (state_reg)
      IDLE: begin
        if (bus.in_valid) begin
          accept     = 1'b1;
          state_next = RUN;
          cnt_next   = '0;
        end
      end
      RUN: begin
        slice_en    = 1'b1;
        slice_first = (cnt_reg == '0);
        slice_xd    = xs_reg[W-1 -: 2];
        slice_yd    = ys_reg[W-1 -: 2];
        if (cnt_reg == RUN_LAST) begin
          state_next = FLUSH;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      FLUSH: begin
        slice_en = (cnt_reg != FLUSH_LAST);
        if (cnt_reg == FLUSH_LAST) begin
          state_next = DONE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Operand shift registers: latch on acceptance, then present the next digit each RUN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xs_reg <= '0;
      ys_reg <= '0;
    end else if (accept) begin
      xs_reg <= bus.x;
      ys_reg <= bus.y;
    end else if (state_reg == RUN) begin
      xs_reg <= {xs_reg[W-3:0], DIG_ZERO};
      ys_reg <= {ys_reg[W-3:0], DIG_ZERO};
    end
  end

  // Result shift register: digits arrive MSD first, so after NDIG+1 shifts the MSD is on top.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z_reg <= '0;
    end else if (slice_zd_valid) begin
      z_reg <= {z_reg[ZW-3:0], slice_zd};
    end
  end

  ol_add_digit u_digit (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (slice_en),
    .first    (slice_first),
    .xd       (slice_xd),
    .yd       (slice_yd),
    .zd       (slice_zd),
    .zd_valid (slice_zd_valid)
  );

  assign bus.in_ready  = (state_reg == IDLE);
  assign bus.busy      = (state_reg != IDLE);
  assign bus.out_valid = (state_reg == DONE);
  assign bus.z         = z_reg;

`ifdef OL_ADD_STREAM_EN
  assign bus.zd       = slice_zd;
  assign bus.zd_valid = slice_zd_valid;
`else
  // Digits are only visible through the packed z.
`endif

endmodule

// File: tb/tb_ol_add_seq_ctrl.sv
// Bench for ol_add_seq_ctrl (NDIG=6): directed cases plus randomized operands checked
// against the numeric value of the borrow-save words. Define OL_ADD_STREAM_EN to also
// check the per-digit stream.
module tb_ol_add_seq_ctrl;

  localparam int NDIG  = 6;
  localparam int DELTA = 2;
  localparam int W     = 2 * NDIG;
  localparam int ZW    = 2 * NDIG + 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  ol_add_seq_ctrl_if #(.NDIG(NDIG)) bus ();

  ol_add_seq_ctrl #(.NDIG(NDIG)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int n_txn    = 0;

`ifdef OL_ADD_STREAM_EN
  logic [ZW-1:0] zcat;
  int            npulse;
`endif

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, $signed(got), $signed(exp));
    end
  endtask

  // Numeric value of an nd-digit borrow-save word (Horner evaluation, MSD first).
  function automatic longint bs_value(input logic [ZW-1:0] v, input int nd);
    longint acc = 0;
    for (int i = nd - 1; i >= 0; i--) begin
      acc = acc * 2 + longint'(v[2*i+1]) - longint'(v[2*i]);
    end
    return acc;
  endfunction

  function automatic int count_11(input logic [ZW-1:0] v);
    int n = 0;
    for (int i = 0; i < NDIG + 1; i++) begin
      if (v[2*i+1] && v[2*i]) n++;
    end
    return n;
  endfunction

  // One full operand/result transaction; hold = cycles of out_ready=0 spent in DONE.
  task automatic run_txn(input logic [W-1:0] xv, input logic [W-1:0] yv, input int in_gap,
                         input int hold, output logic [ZW-1:0] zr, output int lat);
    int            k;
    logic [ZW-1:0] zs;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    repeat (in_gap) @(negedge clk);
    bus.x = xv;
    bus.y = yv;
    bus.in_valid = 1'b1;
    k = 0;
    while (!bus.in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!bus.in_ready) check_val("accept_timeout", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    // Junk on the input side while busy must be ignored.
    bus.x = W'($urandom);
    bus.y = W'($urandom);
    bus.in_valid = 1'($urandom_range(0, 1));
`ifdef OL_ADD_STREAM_EN
    zcat = '0;
    npulse = 0;
`endif
    k = 0;
    while (!bus.out_valid && k < 100) begin
`ifdef OL_ADD_STREAM_EN
      if (bus.zd_valid) begin
        zcat = {zcat[ZW-3:0], bus.zd};
        npulse++;
      end
`endif
      @(posedge clk);
      k++;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    lat = k;
    if (!bus.out_valid) check_val("done_timeout", 64'(bus.out_valid), 64'd1);
    zs = bus.z;
    for (int i = 0; i < hold; i++) begin
      check_val("hold_out_valid", 64'(bus.out_valid), 64'd1);
      check_val("hold_in_ready", 64'(bus.in_ready), 64'd0);
      check_val("hold_z_stable", 64'(bus.z), 64'(zs));
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    check_val("idle_in_ready", 64'(bus.in_ready), 64'd1);
    check_val("idle_out_valid", 64'(bus.out_valid), 64'd0);
    zr = zs;
    n_txn++;
    $display("txn %0d x=%h y=%h z=%h value=%0d lat=%0d", n_txn, xv, yv, zs,
             bs_value(zs, NDIG + 1), lat);
  endtask

  initial begin
    logic [W-1:0]  all_p;
    logic [W-1:0]  all_n;
    logic [W-1:0]  xv;
    logic [W-1:0]  yv;
    logic [ZW-1:0] zr;
    int            lat;

    for (int i = 0; i < NDIG; i++) begin
      all_p[2*i +: 2] = 2'b10;
      all_n[2*i +: 2] = 2'b01;
    end

    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.x = '0;
    bus.y = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_val("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check_val("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check_val("rst_busy", 64'(bus.busy), 64'd0);
    check_val("rst_z", 64'(bus.z), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Case 1: +63 + +63, latency from acceptance to out_valid.
    run_txn(all_p, all_p, 0, 0, zr, lat);
    check_val("c1_sum", 64'(bs_value(zr, NDIG + 1)), 64'd126);
    check_val("c1_latency", 64'(lat), 64'(NDIG + DELTA + 1));
`ifdef OL_ADD_STREAM_EN
    check_val("c1_stream_pulses", 64'(npulse), 64'(NDIG + 1));
    check_val("c1_stream_digits", 64'(zcat), 64'(zr));
`endif

    // Case 2: +63 + -63, then 0 + 0 with every digit {0,0}.
    run_txn(all_p, all_n, 1, 0, zr, lat);
    check_val("c2_cancel", 64'(bs_value(zr, NDIG + 1)), 64'd0);
    run_txn('0, '0, 0, 0, zr, lat);
    check_val("c2_zero_word", 64'(zr), 64'd0);

    // Case 3: consumer stalls five cycles in DONE.
    xv = W'($urandom);
    yv = W'($urandom);
    run_txn(xv, yv, 0, 5, zr, lat);
    check_val("c3_sum", 64'(bs_value(zr, NDIG + 1)),
              64'(bs_value(ZW'(xv), NDIG) + bs_value(ZW'(yv), NDIG)));

    // Case 4: asynchronous reset in the middle of RUN (counter at 3).
    bus.x = all_p;
    bus.y = all_n;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    check_val("c4_busy_run", 64'(bus.busy), 64'd1);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_val("c4_rst_in_ready", 64'(bus.in_ready), 64'd1);
    check_val("c4_rst_out_valid", 64'(bus.out_valid), 64'd0);
    check_val("c4_rst_busy", 64'(bus.busy), 64'd0);
    check_val("c4_rst_z", 64'(bus.z), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    xv = W'($urandom);
    yv = W'($urandom);
    run_txn(xv, yv, 0, 1, zr, lat);
    check_val("c4_after_rst_sum", 64'(bs_value(zr, NDIG + 1)),
              64'(bs_value(ZW'(xv), NDIG) + bs_value(ZW'(yv), NDIG)));

    // Case 5: random digit vectors (including {1,1}) with random handshake gaps.
    for (int t = 0; t < 2000; t++) begin
      xv = W'($urandom);
      yv = W'($urandom);
      run_txn(xv, yv, $urandom_range(0, 2), $urandom_range(0, 2), zr, lat);
      check_val("rnd_sum", 64'(bs_value(zr, NDIG + 1)),
                64'(bs_value(ZW'(xv), NDIG) + bs_value(ZW'(yv), NDIG)));
      check_val("rnd_no_11_digit", 64'(count_11(zr)), 64'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
    $fatal(1, "watchdog");
  end

endmodule
